// File: rtl/mem_stage_responder.sv
// mem_stage_responder: memory-stage data RAM responder for the 16-bit pipeline.
// Accepts one load/store at a time and spends LATENCY cycles in ACCESS.
// A load returns its data with a one-cycle load_valid pulse.
// A request with both read and write set is consumed and flagged on err.
module mem_stage_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        dest_in,
    output logic [DATA_W-1:0] rd_load,
    output logic              load_valid,
    output logic [3:0]        dest_out,
    output logic              busy,
    output logic              err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [TAG_W-1:0]  dest_q;
    logic              is_load_q;
    logic [DATA_W-1:0] rd_load_q;
    logic [TAG_W-1:0]  dest_out_q;
    logic              load_valid_q;
    logic              err_q;
    logic              ready_q;
    logic              busy_q;

    logic idle_req;
    logic legal_req;
    logic illegal_req;
    logic last_access;
    logic store_commit;

    // Request qualification and end-of-access decode
    assign idle_req     = req_valid && (state_q == S_IDLE);
    assign legal_req    = idle_req && (mem_read ^ mem_write);
    assign illegal_req  = idle_req && mem_read && mem_write;
    assign last_access  = (state_q == S_ACCESS) && (cnt_q == '0);
    assign store_commit = last_access && !is_load_q;

    // Data RAM write port; contents survive reset, reset blocks an in-flight commit
    always_ff @(posedge clk) begin
        if (!rst && store_commit) begin
            mem_q[addr_q] <= data_q;
        end
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            dest_q       <= '0;
            is_load_q    <= 1'b0;
            rd_load_q    <= '0;
            dest_out_q   <= '0;
            load_valid_q <= 1'b0;
            err_q        <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (legal_req) begin
                        state_q   <= S_ACCESS;
                        cnt_q     <= CNT_W'(LATENCY - 1);
                        addr_q    <= address;
                        data_q    <= wr_data;
                        dest_q    <= dest_in;
                        is_load_q <= mem_read;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end else if (illegal_req) begin
                        err_q <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (is_load_q) begin
                        rd_load_q    <= mem_q[addr_q];
                        dest_out_q   <= dest_q;
                        load_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign busy       = busy_q;
    assign rd_load    = rd_load_q;
    assign dest_out   = dest_out_q;
    assign load_valid = load_valid_q;
    assign err        = err_q;

endmodule

// File: doc/mem_stage_responder.md
# mem_stage_responder

Data-memory responder for the 16-bit pipelined processor's memory stage. It accepts one load/store request at a time from the execute/ALU side: `mem_read` / `mem_write`, 8-bit `address`, 16-bit store data and a destination register tag. It holds a 256 x 16 data RAM, spends a fixed number of access cycles per request, and returns load data as `rd_load` with a one-cycle valid pulse. `busy` stalls the upstream pipeline.

## Interface
- `ADDR_W`, 8, address width; RAM depth is 2^ADDR_W words.
- `DATA_W`, 16, data word width.
- `LATENCY`, 2, number of cycles spent in ACCESS; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req_valid`  in  1  request present this cycle.
- `req_ready`  out  1  block can accept a request this cycle.
- `mem_read`  in  1  request is a load.
- `mem_write`  in  1  request is a store.
- `address`  in  ADDR_W  word address.
- `wr_data`  in  DATA_W  store data.
- `dest_in`  in  4  destination register tag for loads.
- `rd_load`  out  DATA_W  most recent load data.
- `load_valid`  out  1  one-cycle pulse; `rd_load` / `dest_out` are new this cycle.
- `dest_out`  out  4  tag of the most recent load.
- `busy`  out  1  equals `~req_ready`; pipeline stall.
- `err`  out  1  one-cycle pulse flagging an illegal request.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** `req_ready`=1.
  - Accept happens on an edge where `req_valid` & `req_ready` are both high.
  - On accept, capture `address`, `wr_data`, `dest_in` and the op into internal registers. Inputs are don't-care after the accept edge.
- **Legal accept** (exactly one of `mem_read` / `mem_write`): go to ACCESS and load the cycle counter with `LATENCY`-1.
- **`mem_read` & `mem_write` both high with `req_valid`:**
  - The request is consumed.
  - `err`=1 for the next cycle.
  - No RAM access; state stays IDLE.
- **`req_valid` with neither flag:** not accepted, no state change, no `err`.
- **ACCESS:** `req_ready`=0. The counter decrements each edge. On the edge where the counter is 0:
  - Store: RAM[addr] <= data; go to IDLE. No `load_valid`.
  - Load: `rd_load` <= RAM[addr], `dest_out` <= tag; go to RESP.
- **RESP:** `load_valid`=1 and `req_ready`=0 for exactly this cycle; go to IDLE on the next edge.
- `rd_load` and `dest_out` hold their values until the next load completes.
- Address arithmetic: none. Every address 0x00..0xFF maps to a distinct word; there is no wrap or aliasing.
- **Reset:**
  - State goes to IDLE.
  - Counter = 0.
  - `rd_load`=0, `dest_out`=0, `load_valid`=0, `err`=0, `req_ready`=1, `busy`=0.
  - RAM contents are not cleared.
- **Reset mid-operation:** any in-flight request is dropped. A store in ACCESS is not committed, and a load gives no `load_valid`. `rst` has priority over all other events on the same edge.

## Timing
- Accept on edge E0.
  - Store commits on edge E0+`LATENCY`.
  - Load: `load_valid` is high in the cycle after edge E0+`LATENCY`.
- Occupancy:
  - Store: `req_ready` low for `LATENCY` cycles.
  - Load: `req_ready` low for `LATENCY`+1 cycles.
  - Illegal request: `req_ready` stays high.
- Earliest next accept:
  - After a store: edge E0+`LATENCY`+1.
  - After a load: edge E0+`LATENCY`+2.
- A read of an address in a request accepted right after a store to that same address returns the new data, because the store commits before the next accept.
- `req_valid` may stay high across busy cycles. It is only sampled when `req_ready`=1.
- `err` is high in the cycle after the illegal accept edge, for exactly one cycle.

## Test plan
1. **Store then load.** With `LATENCY`=2, store 0x1234 at 0x05, then load 0x05 with `dest_in`=3.
   - `load_valid` is high for exactly 1 cycle, 3 cycles after the load accept edge.
   - `rd_load`=0x1234, `dest_out`=3.
2. **Address boundaries.** Store 0xAAAA at 0xFF and 0x5555 at 0x00. Load 0xFF, then load 0x00.
   - Responses are 0xAAAA and 0x5555 respectively (no aliasing).
3. **Illegal request.** Drive `mem_read`=`mem_write`=1 with `req_valid` on address 0x05.
   - `err` pulses 1 cycle and `req_ready` never drops.
   - A following load of 0x05 returns 0x1234.
4. **Held request.** Hold `req_valid`=1 for 8 cycles with a load of 0x05.
   - The first accept is at the first edge; the second accept comes 4 edges later.
   - Exactly 2 `load_valid` pulses occur, and `busy` mirrors `~req_ready` throughout.
5. **Reset mid-store.** Store 0xBEEF to 0x05 and assert `rst` in the ACCESS cycle.
   - Next cycle: `req_ready`=1 and all outputs are at reset values.
   - A subsequent load of 0x05 returns 0x1234.
6. **Minimum latency.** Rebuild with `LATENCY`=1. A load accepted on E0 gives `load_valid` in the cycle after E0+1; the next accept is possible on E0+3.
